// File: rtl/ecc_decoder_pipe.sv
// rtl/ecc_decoder_pipe.sv - two-stage SECDED (72,64) decoder with stall handshake and error counters
module ecc_decoder_pipe #(
   parameter int data_bit_width      = 64,
   parameter int redundant_bit_width = 8
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic [data_bit_width+redundant_bit_width-1:0] dec_data_in,
   input  logic                                          dec_valid_in,
   output logic                                          dec_ready_out,
   output logic [data_bit_width-1:0]                     dec_data_out,
   output logic                                          dec_valid_out,
   input  logic                                          dec_ready_in,
   output logic                                          err_single,
   output logic                                          err_double,
   output logic [redundant_bit_width-2:0]                err_pos,
   input  logic                                          clear_counts,
   output logic [15:0]                                   single_count,
   output logic [15:0]                                   double_count
);

   localparam int CW_W  = data_bit_width + redundant_bit_width;
   localparam int SYN_W = redundant_bit_width - 1;

   logic                      advance;
   logic [SYN_W-1:0]          syn_d;
   logic                      par_d;

   logic                      s1_valid_q;
   logic [CW_W-1:0]           s1_cw_q;
   logic [SYN_W-1:0]          s1_syn_q;
   logic                      s1_par_q;

   logic [CW_W-1:0]           flip_d;
   logic [CW_W-1:0]           fixed_cw_d;
   logic [data_bit_width-1:0] data_d;
   logic                      single_d;
   logic                      double_d;
   logic [SYN_W-1:0]          pos_d;

   logic                      valid_q;
   logic [data_bit_width-1:0] data_q;
   logic                      single_q;
   logic                      double_q;
   logic [SYN_W-1:0]          pos_q;
   logic [15:0]               single_cnt_q;
   logic [15:0]               double_cnt_q;

   // Both stages move together; a held output word freezes the whole pipe.
   assign advance       = !valid_q || dec_ready_in;
   assign dec_ready_out = advance;

   // Syndrome is the XOR of the indices of all set bits; bit 0 only feeds overall parity.
   always_comb begin
      syn_d = '0;
      for (int i = 1; i < CW_W; i++) begin
         if (dec_data_in[i]) syn_d = syn_d ^ SYN_W'(i);
      end
      par_d = ^dec_data_in;
   end

   // Classify the syndrome/parity pair, flip the faulty bit and strip parity positions.
   always_comb begin
      single_d = 1'b0;
      double_d = 1'b0;
      pos_d    = '0;
      flip_d   = '0;
      if (s1_par_q) begin
         if (s1_syn_q == '0) begin
            single_d = 1'b1;
         end else if (int'(s1_syn_q) <= CW_W - 1) begin
            single_d = 1'b1;
            pos_d    = s1_syn_q;
            flip_d   = {{(CW_W-1){1'b0}}, 1'b1} << s1_syn_q;
         end else begin
            double_d = 1'b1;
         end
      end else if (s1_syn_q != '0) begin
         double_d = 1'b1;
      end
      fixed_cw_d = s1_cw_q ^ flip_d;
      data_d     = '0;
      begin
         int k;
         k = 0;
         for (int p = 1; p < CW_W; p++) begin
            if (((p & (p - 1)) != 0) && (k < data_bit_width)) begin
               data_d[k] = fixed_cw_d[p];
               k = k + 1;
            end
         end
      end
   end

   // Pipeline registers: stage 1 holds codeword and syndrome, stage 2 holds the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_cw_q    <= '0;
         s1_syn_q   <= '0;
         s1_par_q   <= 1'b0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         single_q   <= 1'b0;
         double_q   <= 1'b0;
         pos_q      <= '0;
      end else if (advance) begin
         s1_valid_q <= dec_valid_in;
         s1_cw_q    <= dec_data_in;
         s1_syn_q   <= syn_d;
         s1_par_q   <= par_d;
         valid_q    <= s1_valid_q;
         data_q     <= data_d;
         single_q   <= s1_valid_q && single_d;
         double_q   <= s1_valid_q && double_d;
         pos_q      <= (s1_valid_q && single_d) ? pos_d : '0;
      end
   end

   // Error counters count delivered words only; clear wins over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (rst || clear_counts) begin
         single_cnt_q <= '0;
         double_cnt_q <= '0;
      end else if (valid_q && dec_ready_in) begin
         if (single_q && (single_cnt_q != 16'hFFFF)) single_cnt_q <= single_cnt_q + 16'd1;
         if (double_q && (double_cnt_q != 16'hFFFF)) double_cnt_q <= double_cnt_q + 16'd1;
      end
   end

   assign dec_valid_out = valid_q;
   assign dec_data_out  = data_q;
   assign err_single    = single_q;
   assign err_double    = double_q;
   assign err_pos       = pos_q;
   assign single_count  = single_cnt_q;
   assign double_count  = double_cnt_q;

endmodule

// File: tb/tb_ecc_decoder_pipe.sv
// tb/tb_ecc_decoder_pipe.sv - directed self-checking bench for ecc_decoder_pipe
module tb_ecc_decoder_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [71:0] dec_data_in;
   logic        dec_valid_in;
   logic        dec_ready_out;
   logic [63:0] dec_data_out;
   logic        dec_valid_out;
   logic        dec_ready_in;
   logic        err_single;
   logic        err_double;
   logic [6:0]  err_pos;
   logic        clear_counts;
   logic [15:0] single_count;
   logic [15:0] double_count;

   int n_checks = 0;
   int n_errors = 0;

   ecc_decoder_pipe #(.data_bit_width(64), .redundant_bit_width(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .dec_data_in  (dec_data_in),
      .dec_valid_in (dec_valid_in),
      .dec_ready_out(dec_ready_out),
      .dec_data_out (dec_data_out),
      .dec_valid_out(dec_valid_out),
      .dec_ready_in (dec_ready_in),
      .err_single   (err_single),
      .err_double   (err_double),
      .err_pos      (err_pos),
      .clear_counts (clear_counts),
      .single_count (single_count),
      .double_count (double_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference SECDED encoder used to build clean codewords from payloads.
   function automatic logic [71:0] encode(input logic [63:0] d);
      logic [71:0] cw;
      logic [6:0]  s;
      int          k;
      cw = '0;
      k  = 0;
      for (int p = 1; p < 72; p++) begin
         if ((p & (p - 1)) != 0) begin
            cw[p] = d[k];
            k++;
         end
      end
      s = '0;
      for (int p = 1; p < 72; p++) if (cw[p]) s = s ^ 7'(p);
      for (int j = 0; j < 7; j++) cw[1 << j] = s[j];
      cw[0] = ^cw[71:1];
      return cw;
   endfunction

   // Send one word into an idle pipe and check the result exactly two edges later.
   task automatic send_one(input string tag, input logic [71:0] cw, input logic [63:0] exp_data,
                           input logic exp_s, input logic exp_d, input logic [6:0] exp_pos);
      dec_data_in  = cw;
      dec_valid_in = 1'b1;
      dec_ready_in = 1'b1;
      @(posedge clk); #1;
      dec_valid_in = 1'b0;
      @(posedge clk); #1;
      check_eq({tag, "_valid"}, dec_valid_out, 1'b1);
      check_eq({tag, "_data"},  dec_data_out, exp_data);
      check_eq({tag, "_single"}, err_single, exp_s);
      check_eq({tag, "_double"}, err_double, exp_d);
      check_eq({tag, "_pos"},    err_pos, exp_pos);
      @(posedge clk); #1;
   endtask

   logic [71:0] cw;
   logic [63:0] d [4];
   int          got;
   int          stall;
   int          seen_valid;

   initial begin
      rst          = 1'b1;
      dec_data_in  = '0;
      dec_valid_in = 1'b0;
      dec_ready_in = 1'b1;
      clear_counts = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      check_eq("rst_valid", dec_valid_out, 1'b0);
      check_eq("rst_data", dec_data_out, 64'h0);
      check_eq("rst_single", err_single, 1'b0);
      check_eq("rst_double", err_double, 1'b0);
      check_eq("rst_pos", err_pos, 7'd0);
      check_eq("rst_scount", single_count, 16'h0);
      check_eq("rst_dcount", double_count, 16'h0);
      check_eq("rst_ready", dec_ready_out, 1'b1);

      // Clean zero word
      send_one("zero", 72'h0, 64'h0, 1'b0, 1'b0, 7'd0);
      check_eq("zero_scount", single_count, 16'd0);
      check_eq("zero_dcount", double_count, 16'd0);

      // Single error on data[1] (position 5)
      cw = '0; cw[5] = 1'b1;
      send_one("pos5", cw, 64'h0, 1'b1, 1'b0, 7'd5);
      check_eq("pos5_scount", single_count, 16'd1);

      // Single error on overall parity bit
      cw = '0; cw[0] = 1'b1;
      send_one("pos0", cw, 64'h0, 1'b1, 1'b0, 7'd0);
      check_eq("pos0_scount", single_count, 16'd2);

      // Double error on positions 3 and 6 passes data[0], data[2] uncorrected
      cw = '0; cw[3] = 1'b1; cw[6] = 1'b1;
      send_one("dbl36", cw, 64'h5, 1'b0, 1'b1, 7'd0);
      check_eq("dbl36_dcount", double_count, 16'd1);

      // Highest position (data[63]) corrected in a non-trivial payload
      cw = encode(64'h0123_4567_89AB_CDEF); cw[71] = ~cw[71];
      send_one("pos71", cw, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 7'd71);

      // Parity set with syndrome 73 (beyond last position) is uncorrectable
      cw = encode(64'hDEAD_BEEF_0000_FFFF); cw[64] = ~cw[64]; cw[8] = ~cw[8]; cw[1] = ~cw[1];
      send_one("syn73", cw, 64'hDEAD_BEEF_0000_FFFF, 1'b0, 1'b1, 7'd0);
      check_eq("syn73_dcount", double_count, 16'd2);
      check_eq("syn73_scount", single_count, 16'd3);

      // Four back-to-back words with a 3-cycle stall on the second
      d[0] = 64'h1111_2222_3333_4444;
      d[1] = 64'hA5A5_5A5A_F0F0_0F0F;
      d[2] = 64'h8000_0000_0000_0001;
      d[3] = 64'hFFFF_FFFF_FFFF_FFFF;
      got   = 0;
      stall = 0;
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               logic acc;
               dec_data_in  = encode(d[i]);
               dec_valid_in = 1'b1;
               acc = 1'b0;
               for (int t = 0; t < 20 && !acc; t++) begin
                  @(negedge clk);
                  acc = dec_ready_out;
                  @(posedge clk); #2;
               end
            end
            dec_valid_in = 1'b0;
         end
         begin
            for (int t = 0; t < 40 && got < 4; t++) begin
               @(posedge clk); #1;
               if (dec_valid_out && got == 1 && stall < 3) begin
                  dec_ready_in = 1'b0;
                  stall++;
               end else begin
                  dec_ready_in = 1'b1;
               end
               @(negedge clk);
               if (!dec_ready_in) begin
                  check_eq("stall_ready", dec_ready_out, 1'b0);
                  check_eq("stall_hold", dec_data_out, d[1]);
               end
               if (dec_valid_out && dec_ready_in) begin
                  check_eq($sformatf("order%0d", got), dec_data_out, d[got]);
                  got++;
               end
            end
            dec_ready_in = 1'b1;
         end
      join
      check_eq("stall_cycles", 72'(stall), 72'd3);
      check_eq("words_delivered", 72'(got), 72'd4);
      seen_valid = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (dec_valid_out) seen_valid++;
      end
      check_eq("no_duplicate", 72'(seen_valid), 72'd0);

      // Reset with two words in flight
      cw = '0; cw[5] = 1'b1;
      dec_data_in  = cw;
      dec_valid_in = 1'b1;
      dec_ready_in = 1'b1;
      @(posedge clk); #1;
      cw = '0; cw[9] = 1'b1;
      dec_data_in = cw;
      @(posedge clk); #1;
      dec_valid_in = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("inflight_valid", dec_valid_out, 1'b0);
      check_eq("inflight_scount", single_count, 16'd0);
      check_eq("inflight_dcount", double_count, 16'd0);
      check_eq("inflight_ready", dec_ready_out, 1'b1);
      seen_valid = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (dec_valid_out) seen_valid++;
      end
      check_eq("inflight_stale", 72'(seen_valid), 72'd0);

      // Saturate single_count with 65535 single-error words
      cw = '0; cw[5] = 1'b1;
      dec_data_in  = cw;
      dec_valid_in = 1'b1;
      repeat (65535) @(posedge clk);
      #1;
      dec_valid_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("sat_full", single_count, 16'hFFFF);
      send_one("sat_a", cw, 64'h0, 1'b1, 1'b0, 7'd5);
      send_one("sat_b", cw, 64'h0, 1'b1, 1'b0, 7'd5);
      check_eq("sat_hold", single_count, 16'hFFFF);

      // A double word so both counters are nonzero before clearing
      cw = '0; cw[3] = 1'b1; cw[6] = 1'b1;
      send_one("pre_clr", cw, 64'h5, 1'b0, 1'b1, 7'd0);
      check_eq("pre_clr_dcount", double_count, 16'd1);

      // clear_counts coincident with a single-error delivery
      cw = '0; cw[5] = 1'b1;
      dec_data_in  = cw;
      dec_valid_in = 1'b1;
      @(posedge clk); #1;
      dec_valid_in = 1'b0;
      @(posedge clk); #1;
      check_eq("clr_valid", dec_valid_out, 1'b1);
      clear_counts = 1'b1;
      @(posedge clk); #1;
      clear_counts = 1'b0;
      check_eq("clr_scount", single_count, 16'd0);
      check_eq("clr_dcount", double_count, 16'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
